// File: rtl/mips_io_pkg.sv
// Shared register-map constants for the memory-mapped I/O port.
package mips_io_pkg;

    typedef enum logic [1:0] {
        OFF_PORT_OUT = 2'd0,
        OFF_PORT_IN  = 2'd1,
        OFF_STATUS   = 2'd2,
        OFF_CTRL     = 2'd3
    } regOff_e;

    localparam int unsigned ST_VALID    = 0;
    localparam int unsigned ST_CHG      = 1;
    localparam int unsigned ST_OVF      = 2;
    localparam int unsigned CTRL_IRQ_EN = 0;

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchronizer for the external input plus a change detector
// comparing the synchronized value with its previous sample.
module io_sync_edge #(
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] asyncIn,
    output logic [IN_WIDTH-1:0] syncIn,
    output logic                changePulse
);

    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] prevIn;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            syncIn <= '0;
            prevIn <= '0;
        end else begin
            sync1  <= asyncIn;
            syncIn <= sync1;
            prevIn <= syncIn;
        end
    end

    // High for exactly one cycle after syncIn takes a new value.
    assign changePulse = (syncIn != prevIn);

endmodule

// File: rtl/mips_io_port.sv
// Memory-mapped I/O port on the MIPS data bus: valid/ready output register,
// synchronized input sample, sticky status bits and an input-change interrupt.
module mips_io_port
    import mips_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          mem_addr_i,
    input  logic [31:0]          mem_wdata_i,
    input  logic                 mem_write_i,
    input  logic                 mem_read_i,
    output logic [31:0]          mem_rdata_o,
    output logic                 sel_o,
    input  logic [IN_WIDTH-1:0]  port_in_i,
    output logic [OUT_WIDTH-1:0] port_out_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 irq_o
);

    logic [IN_WIDTH-1:0] syncIn;
    logic                changePulse;
    logic                inChanged;
    logic                overflow;
    logic                irqEn;
    logic [1:0]          regOff;
    logic                wrEn;
    logic                rdEn;
    logic                outWrite;
    logic                statusWrite;
    logic                ctrlWrite;
    logic                transfer;
    logic [31:0]         statusWord;
    logic                unusedAddrBits;

    io_sync_edge #(
        .IN_WIDTH(IN_WIDTH)
    ) uSyncEdge (
        .clk        (clk),
        .reset      (reset),
        .asyncIn    (port_in_i),
        .syncIn     (syncIn),
        .changePulse(changePulse)
    );

    assign unusedAddrBits = ^mem_addr_i[1:0];

    assign sel_o       = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
    assign regOff      = mem_addr_i[3:2];
    assign wrEn        = sel_o & mem_write_i;
    assign rdEn        = sel_o & mem_read_i;
    assign outWrite    = wrEn & (regOff == OFF_PORT_OUT);
    assign statusWrite = wrEn & (regOff == OFF_STATUS);
    assign ctrlWrite   = wrEn & (regOff == OFF_CTRL);
    assign transfer    = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_o  <= '0;
            out_valid_o <= 1'b0;
            inChanged   <= 1'b0;
            overflow    <= 1'b0;
            irqEn       <= 1'b0;
        end else begin
            if (outWrite) begin
                port_out_o  <= OUT_WIDTH'(mem_wdata_i);
                out_valid_o <= 1'b1;
            end else if (transfer) begin
                out_valid_o <= 1'b0;
            end
            // Set conditions are OR'ed after the W1C mask so a same-edge set wins.
            inChanged <= changePulse |
                         (inChanged & ~(statusWrite & mem_wdata_i[ST_CHG]));
            overflow  <= (outWrite & out_valid_o & ~out_ready_i) |
                         (overflow & ~(statusWrite & mem_wdata_i[ST_OVF]));
            if (ctrlWrite) begin
                irqEn <= mem_wdata_i[CTRL_IRQ_EN];
            end
        end
    end

    always_comb begin
        statusWord           = '0;
        statusWord[ST_VALID] = out_valid_o;
        statusWord[ST_CHG]   = inChanged;
        statusWord[ST_OVF]   = overflow;
    end

    always_comb begin
        mem_rdata_o = '0;
        if (rdEn) begin
            unique case (regOff)
                OFF_PORT_OUT: mem_rdata_o = 32'(port_out_o);
                OFF_PORT_IN:  mem_rdata_o = 32'(syncIn);
                OFF_STATUS:   mem_rdata_o = statusWord;
                OFF_CTRL:     mem_rdata_o[CTRL_IRQ_EN] = irqEn;
                default:      mem_rdata_o = '0;
            endcase
        end
    end

    assign irq_o = irqEn & inChanged;

endmodule

// File: tb/tb_mips_io_port.sv
// Directed bench for mips_io_port: expected values are queued as stimulus is
// driven and popped against DUT outputs.
module tb_mips_io_port;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memWrite;
    logic        memRead;
    logic [31:0] memRdata;
    logic        sel;
    logic [7:0]  portIn;
    logic [31:0] portOut;
    logic        outValid;
    logic        outReady;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } expItem_t;

    expItem_t    sb[$];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    mips_io_port #(
        .BASE_ADDR(BASE),
        .IN_WIDTH (8),
        .OUT_WIDTH(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr_i (memAddr),
        .mem_wdata_i(memWdata),
        .mem_write_i(memWrite),
        .mem_read_i (memRead),
        .mem_rdata_o(memRdata),
        .sel_o      (sel),
        .port_in_i  (portIn),
        .port_out_o (portOut),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic pushExp(input string tag, input logic [31:0] v);
        expItem_t it;
        it.tag = tag;
        it.exp = v;
        sb.push_back(it);
    endtask

    task automatic popCmp(input logic [31:0] obs);
        expItem_t it;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp)
            else begin
                mismatched++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        memAddr  = a;
        memWdata = d;
        memWrite = 1'b1;
        tick();
        memWrite = 1'b0;
    endtask

    task automatic lwCheck(input string tag, input logic [31:0] a, input logic [31:0] e);
        memAddr = a;
        memRead = 1'b1;
        pushExp(tag, e);
        #1;
        popCmp(memRdata);
        memRead = 1'b0;
    endtask

    task automatic outCheck(input string tag, input logic [31:0] eData,
                            input logic eValid, input logic eIrq);
        pushExp({tag, "_data"}, eData);
        pushExp({tag, "_valid"}, {31'b0, eValid});
        pushExp({tag, "_irq"}, {31'b0, eIrq});
        popCmp(portOut);
        popCmp({31'b0, outValid});
        popCmp({31'b0, irq});
    endtask

    initial begin
        reset    = 1'b1;
        memAddr  = '0;
        memWdata = '0;
        memWrite = 1'b0;
        memRead  = 1'b0;
        portIn   = '0;
        outReady = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        outCheck("rst", 32'h0, 1'b0, 1'b0);
        lwCheck("rst_status", BASE + 32'h8, 32'h0);
        lwCheck("rst_ctrl", BASE + 32'hC, 32'h0);
        lwCheck("rst_in", BASE + 32'h4, 32'h0);

        // 1: basic store
        sw(BASE, 32'hDEAD_BEEF);
        outCheck("sw1", 32'hDEAD_BEEF, 1'b1, 1'b0);
        lwCheck("sw1_status", BASE + 32'h8, 32'h1);
        lwCheck("sw1_readback", BASE + 32'h3, 32'hDEAD_BEEF);

        // 2: transfer, idle ready, write on transfer edge
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        outCheck("xfer", 32'hDEAD_BEEF, 1'b0, 1'b0);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        outCheck("idle_ready", 32'hDEAD_BEEF, 1'b0, 1'b0);
        sw(BASE, 32'hDEAD_BEEF);
        outReady = 1'b1;
        sw(BASE, 32'h5);
        outReady = 1'b0;
        outCheck("xfer_wr", 32'h5, 1'b1, 1'b0);
        lwCheck("xfer_wr_status", BASE + 32'h8, 32'h1);

        // 3: overflow and W1C
        sw(BASE, 32'h7);
        outCheck("ovf", 32'h7, 1'b1, 1'b0);
        lwCheck("ovf_status", BASE + 32'h8, 32'h5);
        sw(BASE + 32'h8, 32'h4);
        lwCheck("ovf_clr", BASE + 32'h8, 32'h1);

        // 4: input synchronizer and interrupt
        portIn = 8'h03;
        lwCheck("in_e0", BASE + 32'h4, 32'h0);
        tick();
        lwCheck("in_e1", BASE + 32'h4, 32'h0);
        tick();
        lwCheck("in_e2", BASE + 32'h4, 32'h3);
        lwCheck("chg_e2", BASE + 32'h8, 32'h1);
        tick();
        lwCheck("chg_e3", BASE + 32'h8, 32'h3);
        outCheck("irq_off", 32'h7, 1'b1, 1'b0);
        sw(BASE + 32'hC, 32'hFFFF_FFFF);
        lwCheck("ctrl_rd", BASE + 32'hC, 32'h1);
        outCheck("irq_on", 32'h7, 1'b1, 1'b1);
        sw(BASE + 32'h8, 32'h2);
        outCheck("irq_clr", 32'h7, 1'b1, 1'b0);
        lwCheck("chg_clr", BASE + 32'h8, 32'h1);

        // 5: set beats clear on the same edge
        portIn = 8'h05;
        tick();
        tick();
        lwCheck("chg_pre", BASE + 32'h8, 32'h1);
        sw(BASE + 32'h8, 32'h2);
        lwCheck("set_wins", BASE + 32'h8, 32'h3);
        outCheck("set_wins", 32'h7, 1'b1, 1'b1);

        // Out-of-window and write-ignored cases
        memAddr = BASE + 32'h10;
        memRead = 1'b1;
        pushExp("oow_sel", 32'h0);
        pushExp("oow_rdata", 32'h0);
        #1;
        popCmp({31'b0, sel});
        popCmp(memRdata);
        memRead = 1'b0;
        sw(BASE + 32'h10, 32'h99);
        outCheck("oow_sw", 32'h7, 1'b1, 1'b1);
        memAddr = BASE + 32'h4;
        pushExp("win_sel", 32'h1);
        pushExp("no_read", 32'h0);
        #1;
        popCmp({31'b0, sel});
        popCmp(memRdata);
        sw(BASE + 32'h4, 32'hFFFF_FFFF);
        outCheck("sw_in", 32'h7, 1'b1, 1'b1);
        lwCheck("sw_in_in", BASE + 32'h4, 32'h5);
        lwCheck("sw_in_status", BASE + 32'h8, 32'h3);

        // Simultaneous read and write returns the pre-write value
        memAddr  = BASE;
        memWdata = 32'hAA;
        memWrite = 1'b1;
        memRead  = 1'b1;
        pushExp("rw_pre", 32'h7);
        #1;
        popCmp(memRdata);
        tick();
        memWrite = 1'b0;
        memRead  = 1'b0;
        outCheck("rw_post", 32'hAA, 1'b1, 1'b1);
        lwCheck("rw_status", BASE + 32'h8, 32'h7);

        // 6: reset mid-handshake
        reset = 1'b1;
        tick();
        outCheck("rst2", 32'h0, 1'b0, 1'b0);
        lwCheck("rst2_status", BASE + 32'h8, 32'h0);
        lwCheck("rst2_ctrl", BASE + 32'hC, 32'h0);
        lwCheck("rst2_in", BASE + 32'h4, 32'h0);
        reset = 1'b0;
        tick();

        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_io_port.md
Name: mips_io_port

Overview:
- Memory-mapped I/O port responder on the MIPS processor data-memory bus.
- The core is the initiator and issues sw/lw to the port's address window.
- The block delivers writes to an external consumer through a valid/ready output handshake, and returns a synchronized sample of the external 8-bit input.
- It sits beside data memory; the core's read-data mux selects it when sel_o=1.

Parameters:
- BASE_ADDR, 32'h1001_0000: window base; 16-byte aligned.
- IN_WIDTH, 8: external input width.
- OUT_WIDTH, 32: output port width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr_i  input  32  byte address from core.
- mem_wdata_i  input  32  store data.
- mem_write_i  input  1  store strobe, one cycle per sw.
- mem_read_i  input  1  load strobe.
- mem_rdata_o  output  32  load data (combinational).
- sel_o  output  1  address hits window.
- port_in_i  input  IN_WIDTH  asynchronous external input.
- port_out_o  output  OUT_WIDTH  output data to consumer.
- out_valid_o  output  1  port_out_o holds unconsumed data.
- out_ready_i  input  1  consumer accepts data.
- irq_o  output  1  input-change interrupt request.

Behaviour:
- Decode:
  - sel_o = (mem_addr_i[31:4] == BASE_ADDR[31:4]).
  - Register offset = mem_addr_i[3:2]; bits [1:0] ignored.
  - Access strobes act only when sel_o=1.
- Register map:
  - 0x0 PORT_OUT (RW): read returns port_out_o.
  - 0x4 PORT_IN (RO): zero-extended sync_in; writes ignored.
  - 0x8 STATUS: bit0 out_valid (RO), bit1 in_changed, bit2 overflow. Bits 1 and 2 are sticky, write-1-to-clear.
  - 0xC CTRL: bit0 irq_en (RW); other bits read 0.
- Read path:
  - mem_rdata_o is the selected register when sel_o & mem_read_i; otherwise 32'h0.
  - Zero added latency, which suits a single-cycle core.
- Output handshake:
  - A sw to PORT_OUT loads port_out_o <= mem_wdata_i and sets out_valid_o=1 on the next edge.
  - Transfer occurs on an edge where out_valid_o & out_ready_i; out_valid_o clears after that edge.
  - port_out_o is stable while valid, except on overwrite.
  - Write on the same edge as a transfer: new data loads, out_valid_o stays 1, no overflow.
  - Write while out_valid_o=1 and out_ready_i=0: data overwritten, out_valid_o stays 1, overflow sets.
  - out_ready_i while out_valid_o=0: no effect.
- Input path:
  - Two-flop synchronizer sync1 -> sync_in, then prev_in <= sync_in.
  - A port_in_i change is readable after 2 edges; in_changed sets on the 3rd edge (sync_in != prev_in).
- Sticky bits: a set condition and a W1C clear on the same edge -> set wins.
- irq_o = irq_en & in_changed (combinational from registers).
- Reset, effective on the next edge, including mid-handshake:
  - port_out_o=0, out_valid_o=0.
  - in_changed=0, overflow=0, irq_en=0.
  - sync1=sync_in=prev_in=0.
  - A pending transfer is dropped.
  - The core's reset is active-low; the top-level drives this block's reset from the inverted core reset.
- Simultaneous mem_read_i and mem_write_i: the read returns pre-write values.

Decomposition:
- Shared package mips_io_pkg:
  - Offset constants OFF_PORT_OUT=2'd0, OFF_PORT_IN=2'd1, OFF_STATUS=2'd2, OFF_CTRL=2'd3.
  - STATUS bit indices ST_VALID=0, ST_CHG=1, ST_OVF=2.
  - CTRL bit CTRL_IRQ_EN=0.
- One sub-module, io_sync_edge: IN_WIDTH-wide two-flop synchronizer plus change detector. Outputs sync_in and a one-cycle change pulse.

Test Plan:
1. After reset, sw 32'hDEAD_BEEF to 0x1001_0000 with out_ready_i=0 -> next edge: port_out_o=DEAD_BEEF, out_valid_o=1; lw 0x1001_0008 returns 32'h1.
2. Hold case 1, assert out_ready_i one cycle -> out_valid_o=0 after that edge. Repeat with sw 32'h5 on the same edge as out_ready_i=1 -> port_out_o=5, out_valid_o=1, STATUS bit2=0.
3. With out_valid_o=1 and out_ready_i=0, sw 32'h7 -> port_out_o=7, STATUS=32'h5. sw 32'h4 to 0x1001_0008 -> STATUS=32'h1.
4. port_in_i changes 0 -> 3 -> lw 0x1001_0004 returns 0 one edge later and 3 two edges later. in_changed sets on the 3rd edge. With CTRL=1, irq_o=1; W1C 32'h2 clears irq_o.
5. Same-edge W1C of in_changed with a new input change -> bit1 remains 1. lw 0x1001_0010 -> sel_o=0, mem_rdata_o=0. sw to PORT_IN -> no state change.
6. Assert reset mid-handshake (out_valid_o=1, overflow=1, irq_en=1) -> all outputs and STATUS/CTRL read 0 on the next edge.
